decoder_2_to_4_seq: RTL and testbench

//  Registered 2-to-4 decoder: the receive-side counterpart of the 4-to-2 encoder.
//  - Accepts a 2-bit code {a,b} through a valid/ready handshake.
//  - Drives the matching one-hot line d0..d3.
//  - A built-in scan mode walks a single '1' across d0..d3, holding each line for a

---
 rtl/decoder_2_to_4_seq_if.sv | 27 ++
 rtl/decoder_2_to_4_seq.sv | 132 +++++++++++++
 tb/tb_decoder_2_to_4_seq.sv | 134 +++++++++++++
 3 files changed

// File: rtl/decoder_2_to_4_seq_if.sv
// Handshake and output bundle for the registered 2-to-4 decoder.
// The master drives codes and scan requests; the slave (decoder) drives the one-hot lines.
interface decoder_2_to_4_seq_if;
  logic en;
  logic in_valid;
  logic a;
  logic b;
  logic in_ready;
  logic scan_start;
  logic d0;
  logic d1;
  logic d2;
  logic d3;
  logic out_valid;
  logic busy;
  logic scan_done;

  modport master (
    output en, in_valid, a, b, scan_start,
    input  in_ready, d0, d1, d2, d3, out_valid, busy, scan_done
  );

  modport slave (
    input  en, in_valid, a, b, scan_start,
    output in_ready, d0, d1, d2, d3, out_valid, busy, scan_done
  );
endinterface

// File: rtl/decoder_2_to_4_seq.sv
// Registered 2-to-4 decoder with valid/ready input and a walking-one scan mode
// that holds each output line high for DWELL cycles.
module decoder_2_to_4_seq #(
  parameter int DWELL   = 4,
  parameter int DWELL_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  decoder_2_to_4_seq_if.slave  bus
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SCAN = 1'b1
  } state_e;

  localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(DWELL - 1);

  state_e             state_q, state_d;
  logic [3:0]         d_q, d_d;
  logic               out_valid_q, out_valid_d;
  logic               busy_q, busy_d;
  logic               scan_done_q, scan_done_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic [1:0]         line_q, line_d;

  logic               in_ready_s;
  logic               dwell_end_s;
  logic               last_step_s;
  logic [1:0]         line_nx_s;
  logic [1:0]         code_s;

  assign code_s      = {bus.a, bus.b};
  assign in_ready_s  = (state_q == ST_IDLE) & bus.en & ~rst;
  assign dwell_end_s = (cnt_q == DWELL_LAST);
  assign last_step_s = (state_q == ST_SCAN) & dwell_end_s & (line_q == 2'd3);
  assign line_nx_s   = line_q + 2'd1;

  // State and output registers; reset wins over everything, including mid-scan.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      d_q         <= 4'b0000;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      scan_done_q <= 1'b0;
      cnt_q       <= '0;
      line_q      <= 2'd0;
    end else begin
      state_q     <= state_d;
      d_q         <= d_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      scan_done_q <= scan_done_d;
      cnt_q       <= cnt_d;
      line_q      <= line_d;
    end
  end

  // Next-state logic: scan_start leaves IDLE regardless of en.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.scan_start) state_d = ST_SCAN;
        else                state_d = ST_IDLE;
      end
      ST_SCAN: begin
        if (last_step_s) state_d = ST_IDLE;
        else             state_d = ST_SCAN;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output/datapath logic: decode in IDLE, walking one with dwell counter in SCAN.
  always_comb begin
    d_d         = d_q;
    out_valid_d = 1'b0;
    busy_d      = 1'b0;
    scan_done_d = 1'b0;
    cnt_d       = cnt_q;
    line_d      = line_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.scan_start) begin
          d_d    = 4'b0001;
          busy_d = 1'b1;
          cnt_d  = '0;
          line_d = 2'd0;
        end else if (bus.in_valid && in_ready_s) begin
          d_d         = 4'b0001 << code_s;
          out_valid_d = 1'b1;
        end else begin
          d_d = d_q;
        end
      end
      ST_SCAN: begin
        busy_d = 1'b1;
        if (dwell_end_s) begin
          cnt_d = '0;
          if (line_q == 2'd3) begin
            d_d         = 4'b0000;
            busy_d      = 1'b0;
            scan_done_d = 1'b1;
            line_d      = 2'd0;
          end else begin
            line_d = line_nx_s;
            d_d    = 4'b0001 << line_nx_s;
          end
        end else begin
          cnt_d = cnt_q + {{(DWELL_W-1){1'b0}}, 1'b1};
        end
      end
      default: begin
        d_d    = 4'b0000;
        cnt_d  = '0;
        line_d = 2'd0;
      end
    endcase
  end

  assign bus.in_ready  = in_ready_s;
  assign bus.d0        = d_q[0];
  assign bus.d1        = d_q[1];
  assign bus.d2        = d_q[2];
  assign bus.d3        = d_q[3];
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = busy_q;
  assign bus.scan_done = scan_done_q;

endmodule

// File: tb/tb_decoder_2_to_4_seq.sv
// Self-checking bench: table-driven decode vectors plus hand-written scan/reset sequences,
// with expected outputs queued at drive time and compared after the clock edge.
module tb_decoder_2_to_4_seq;
  localparam int DWELL = 4;

  typedef struct packed {
    logic [3:0] d;
    logic       ov;
    logic       busy;
    logic       done;
  } exp_t;

  typedef struct {
    logic       en;
    logic       iv;
    logic       a;
    logic       b;
    logic       ss;
    logic       rdy;
    logic [3:0] d;
    logic       ov;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];

  decoder_2_to_4_seq_if dif ();

  decoder_2_to_4_seq #(.DWELL(DWELL), .DWELL_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (dif)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach summary, got running required finished");
    $fatal(1);
  end

  function automatic exp_t mk(input logic [3:0] d, input logic ov, input logic busy, input logic done);
    exp_t e;
    e.d = d; e.ov = ov; e.busy = busy; e.done = done;
    return e;
  endfunction

  // One clock: drive at negedge, check in_ready, queue expectation, compare after posedge.
  task automatic step(input logic rst_v, input logic en_v, input logic iv_v, input logic a_v,
                      input logic b_v, input logic ss_v, input logic exp_rdy, input exp_t e,
                      input string name);
    exp_t got;
    exp_t want;
    @(negedge clk);
    rst = rst_v; dif.en = en_v; dif.in_valid = iv_v; dif.a = a_v; dif.b = b_v; dif.scan_start = ss_v;
    #1;
    checks++;
    if (dif.in_ready !== exp_rdy) begin
      errors++;
      $display("FAIL %s.in_ready: got %b required %b", name, dif.in_ready, exp_rdy);
    end
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    got = mk({dif.d3, dif.d2, dif.d1, dif.d0}, dif.out_valid, dif.busy, dif.scan_done);
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s.queue: got empty required entry", name);
    end else begin
      want = exp_q.pop_front();
      if (got !== want) begin
        errors++;
        $display("FAIL %s.outputs: got d=%b ov=%b busy=%b done=%b required d=%b ov=%b busy=%b done=%b",
                 name, got.d, got.ov, got.busy, got.done, want.d, want.ov, want.busy, want.done);
      end
    end
  endtask

  // Continue a scan started at call 0 through call `last`; stray requests must be ignored.
  task automatic run_scan(input int last, input string name);
    for (int c = 1; c <= last; c++) begin
      if (c == 4 * DWELL)
        step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, mk(4'b0000, 1'b0, 1'b0, 1'b1), name);
      else
        step(1'b0, 1'b1, c[0], 1'b1, c[1], c[2], 1'b0,
             mk(4'(4'b0001 << (c / DWELL)), 1'b0, 1'b1, 1'b0), name);
    end
  endtask

  vec_t vecs[6];

  initial begin
    vecs[0] = '{en:1'b1, iv:1'b1, a:1'b0, b:1'b0, ss:1'b0, rdy:1'b1, d:4'b0001, ov:1'b1};
    vecs[1] = '{en:1'b1, iv:1'b1, a:1'b0, b:1'b1, ss:1'b0, rdy:1'b1, d:4'b0010, ov:1'b1};
    vecs[2] = '{en:1'b1, iv:1'b1, a:1'b1, b:1'b0, ss:1'b0, rdy:1'b1, d:4'b0100, ov:1'b1};
    vecs[3] = '{en:1'b1, iv:1'b1, a:1'b1, b:1'b1, ss:1'b0, rdy:1'b1, d:4'b1000, ov:1'b1};
    vecs[4] = '{en:1'b0, iv:1'b1, a:1'b1, b:1'b0, ss:1'b0, rdy:1'b0, d:4'b1000, ov:1'b0};
    vecs[5] = '{en:1'b1, iv:1'b0, a:1'b0, b:1'b1, ss:1'b0, rdy:1'b1, d:4'b1000, ov:1'b0};

    dif.en = 1'b0; dif.in_valid = 1'b0; dif.a = 1'b0; dif.b = 1'b0; dif.scan_start = 1'b0;

    // Reset with requests pending: everything stays clear.
    for (int i = 0; i < 2; i++)
      step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, mk(4'b0000, 1'b0, 1'b0, 1'b0), "reset");

    foreach (vecs[i])
      step(1'b0, vecs[i].en, vecs[i].iv, vecs[i].a, vecs[i].b, vecs[i].ss, vecs[i].rdy,
           mk(vecs[i].d, vecs[i].ov, 1'b0, 1'b0), $sformatf("vec%0d", i));

    // Full scan with en low at start: walking one, then done pulse and ready again.
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, mk(4'b0001, 1'b0, 1'b1, 1'b0), "scan.start");
    run_scan(4 * DWELL, "scan");
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, mk(4'b0000, 1'b0, 1'b0, 1'b0), "scan.after");

    // scan_start beats a simultaneous code 11 decode.
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, mk(4'b0001, 1'b0, 1'b1, 1'b0), "prio.start");
    run_scan(4 * DWELL, "prio");

    // Reset mid-scan while d2 is high, then an immediate decode of 01.
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, mk(4'b0001, 1'b0, 1'b1, 1'b0), "midrst.start");
    run_scan(2 * DWELL, "midrst");
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, mk(4'b0000, 1'b0, 1'b0, 1'b0), "midrst.rst");
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, mk(4'b0010, 1'b1, 1'b0, 1'b0), "midrst.dec01");
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, mk(4'b0010, 1'b0, 1'b0, 1'b0), "midrst.hold");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
